// File: rtl/video_levels.sv
// Shared composite video level codes and nominal timing constants.
// Used by both the pixel generator and the sync decoder.
package video_levels;

    localparam logic [2:0] LVL_SYNC  = 3'b000;
    localparam logic [2:0] LVL_BLACK = 3'b001;
    localparam logic [2:0] LVL_GRAY0 = 3'b010;
    localparam logic [2:0] LVL_GRAY1 = 3'b011;
    localparam logic [2:0] LVL_GRAY2 = 3'b100;
    localparam logic [2:0] LVL_GRAY3 = 3'b101;
    localparam logic [2:0] LVL_GRAY4 = 3'b110;
    localparam logic [2:0] LVL_GRAY5 = 3'b111;

    localparam int LINE_CLKS_NOM      = 1728;
    localparam int LINE_TOL_NOM       = 16;
    localparam int HSYNC_MIN_NOM      = 64;
    localparam int HSYNC_MAX_NOM      = 200;
    localparam int VSYNC_MIN_NOM      = 400;
    localparam int H_ACTIVE_START_NOM = 284;
    localparam int H_ACTIVE_LEN_NOM   = 1404;
    localparam int V_ACTIVE_START_NOM = 23;
    localparam int V_ACTIVE_END_NOM   = 310;
    localparam int LOCK_LINES_NOM     = 4;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_LOCKING = 2'd1,
        ST_LOCKED  = 2'd2
    } lock_state_e;

    // Half-open window test [lo, hi)
    function automatic logic in_span(
        input logic [10:0] v,
        input logic [10:0] lo,
        input logic [10:0] hi
    );
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/sync_pulse_classifier.sv
// Measures sync-level runs and classifies each finished run
// as a line sync or a broad (vertical) pulse.
module sync_pulse_classifier
    import video_levels::*;
#(
    parameter int HSYNC_MIN = HSYNC_MIN_NOM,
    parameter int HSYNC_MAX = HSYNC_MAX_NOM,
    parameter int VSYNC_MIN = VSYNC_MIN_NOM
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [2:0] level_i,
    output logic       line_sync_o,
    output logic       broad_sync_o
);

    localparam logic [9:0] RUN_MAX = 10'h3ff;
    localparam logic [9:0] H_MIN   = 10'(HSYNC_MIN);
    localparam logic [9:0] H_MAX   = 10'(HSYNC_MAX);
    localparam logic [9:0] V_MIN   = 10'(VSYNC_MIN);

    logic [9:0] run_q;
    logic [9:0] run_d;
    logic       is_sync;

    assign is_sync = (level_i == LVL_SYNC);

    // Saturating length of the current sync run
    always_comb begin
        run_d = run_q;
        if (!is_sync) begin
            run_d = '0;
        end else if (run_q != RUN_MAX) begin
            run_d = run_q + 10'd1;
        end
    end

    // Run counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end

    // Classify the finished run on the first non-sync sample
    always_comb begin
        line_sync_o  = 1'b0;
        broad_sync_o = 1'b0;
        if (!is_sync) begin
            if ((run_q >= H_MIN) && (run_q <= H_MAX)) begin
                line_sync_o = 1'b1;
            end else if (run_q >= V_MIN) begin
                broad_sync_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/composite_sync_decoder.sv
// Composite sync decoder: line lock, field/line counting and
// regeneration of the active-picture window and level stream.
module composite_sync_decoder
    import video_levels::*;
#(
    parameter int LINE_CLKS      = LINE_CLKS_NOM,
    parameter int LINE_TOL       = LINE_TOL_NOM,
    parameter int HSYNC_MIN      = HSYNC_MIN_NOM,
    parameter int HSYNC_MAX      = HSYNC_MAX_NOM,
    parameter int VSYNC_MIN      = VSYNC_MIN_NOM,
    parameter int H_ACTIVE_START = H_ACTIVE_START_NOM,
    parameter int H_ACTIVE_LEN   = H_ACTIVE_LEN_NOM,
    parameter int V_ACTIVE_START = V_ACTIVE_START_NOM,
    parameter int V_ACTIVE_END   = V_ACTIVE_END_NOM,
    parameter int LOCK_LINES     = LOCK_LINES_NOM
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [2:0] level_in,
    output logic       hsync_det,
    output logic       vsync_det,
    output logic       locked,
    output logic       row_enable,
    output logic [8:0] vert_c,
    output logic [2:0] pixel_level
);

    localparam int GW = $clog2(LOCK_LINES + 1);

    localparam logic [10:0] H_SAT    = 11'h7ff;
    localparam logic [8:0]  V_SAT    = 9'h1ff;
    localparam logic [10:0] LINE_MIN = 11'(LINE_CLKS - LINE_TOL);
    localparam logic [10:0] LINE_MAX = 11'(LINE_CLKS + LINE_TOL);
    localparam logic [10:0] HA_LO    = 11'(H_ACTIVE_START);
    localparam logic [10:0] HA_HI    = 11'(H_ACTIVE_START + H_ACTIVE_LEN);
    localparam logic [10:0] VA_LO    = 11'(V_ACTIVE_START);
    localparam logic [10:0] VA_HI    = 11'(V_ACTIVE_END);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_LINES - 1);

    logic line_sync;
    logic broad_sync;

    logic [10:0]   h_q, h_d;
    logic [8:0]    vert_q, vert_d;
    logic          armed_q, armed_d;
    logic          seen_q, seen_d;
    logic          hs_q, vs_q, ok_q;
    logic          line_ok;
    logic          timeout;
    lock_state_e   state_q, state_d;
    logic [GW-1:0] good_q, good_d;
    logic          row_q, row_d;
    logic [2:0]    pix_q, pix_d;

    sync_pulse_classifier #(
        .HSYNC_MIN (HSYNC_MIN),
        .HSYNC_MAX (HSYNC_MAX),
        .VSYNC_MIN (VSYNC_MIN)
    ) u_cls (
        .clk_i        (sys_clk),
        .rst_i        (sys_rst),
        .level_i      (level_in),
        .line_sync_o  (line_sync),
        .broad_sync_o (broad_sync)
    );

    assign line_ok = line_sync && (h_q >= LINE_MIN) && (h_q <= LINE_MAX);
    assign timeout = (h_q >= LINE_MAX) && !line_sync;

    // Horizontal position, line number and field-start bookkeeping
    always_comb begin
        h_d     = h_q;
        vert_d  = vert_q;
        armed_d = armed_q;
        seen_d  = seen_q;
        if (line_sync) begin
            h_d     = '0;
            seen_d  = 1'b1;
            armed_d = 1'b0;
            if (armed_q) begin
                vert_d = '0;
            end else if (vert_q != V_SAT) begin
                vert_d = vert_q + 9'd1;
            end
        end else begin
            if (h_q != H_SAT) begin
                h_d = h_q + 11'd1;
            end
            if (broad_sync) begin
                armed_d = 1'b1;
                seen_d  = 1'b0;
            end
        end
    end

    // Lock FSM next state; lines are judged one cycle after detection
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        unique case (state_q)
            ST_SEARCH: begin
                if (hs_q) begin
                    state_d = ST_LOCKING;
                    good_d  = '0;
                end
            end
            ST_LOCKING: begin
                if (hs_q) begin
                    if (!ok_q) begin
                        good_d = '0;
                    end else if (good_q == GOOD_LAST) begin
                        state_d = ST_LOCKED;
                    end else begin
                        good_d = good_q + 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                if ((hs_q && !ok_q) || timeout) begin
                    state_d = ST_SEARCH;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    // Lock FSM output
    always_comb begin
        locked = (state_q == ST_LOCKED);
    end

    // Active-picture window and level echo for the next cycle
    always_comb begin
        row_d = locked
             && in_span({2'b00, vert_q}, VA_LO, VA_HI)
             && in_span(h_q, HA_LO, HA_HI);
        pix_d = row_d ? level_in : LVL_BLACK;
    end

    // State and output registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            h_q     <= '0;
            vert_q  <= '0;
            armed_q <= 1'b0;
            seen_q  <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            ok_q    <= 1'b0;
            state_q <= ST_SEARCH;
            good_q  <= '0;
            row_q   <= 1'b0;
            pix_q   <= LVL_BLACK;
        end else begin
            h_q     <= h_d;
            vert_q  <= vert_d;
            armed_q <= armed_d;
            seen_q  <= seen_d;
            hs_q    <= line_sync;
            vs_q    <= broad_sync && seen_q;
            ok_q    <= line_ok;
            state_q <= state_d;
            good_q  <= good_d;
            row_q   <= row_d;
            pix_q   <= pix_d;
        end
    end

    assign hsync_det   = hs_q;
    assign vsync_det   = vs_q;
    assign vert_c      = vert_q;
    assign row_enable  = row_q;
    assign pixel_level = pix_q;

endmodule

// File: tb/tb_composite_sync_decoder.sv
// Scoreboard bench for composite_sync_decoder with a
// timestamp-based reference model of line/field recovery.
module tb_composite_sync_decoder;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [2:0] level_in = 3'b001;
    logic       hsync_det;
    logic       vsync_det;
    logic       locked;
    logic       row_enable;
    logic [8:0] vert_c;
    logic [2:0] pixel_level;

    composite_sync_decoder dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .level_in    (level_in),
        .hsync_det   (hsync_det),
        .vsync_det   (vsync_det),
        .locked      (locked),
        .row_enable  (row_enable),
        .vert_c      (vert_c),
        .pixel_level (pixel_level)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = -1;
    always @(posedge sys_clk) cyc <= cyc + 1;

    localparam int K_HS = 0;
    localparam int K_VS = 1;
    localparam int K_LK = 2;
    localparam int K_PX = 3;
    localparam int K_RS = 4;

    typedef struct {
        int kind;
        int t;
        int val;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // reference model state: h is derived from the time of the last line start
    int m_run = 0;
    int m_last_hs = 0;
    int m_lock = 0;
    int m_good = 0;
    int m_vert = 0;
    bit m_armed = 0;
    bit m_seen = 0;
    bit m_pend = 0;
    bit m_pend_ok = 0;

    function automatic string kname(int k);
        case (k)
            K_HS: return "hsync";
            K_VS: return "vsync";
            K_LK: return "locked";
            K_PX: return "pixel";
            default: return "reset_state";
        endcase
    endfunction

    task automatic push(int k, int t, int v);
        exp_t e;
        e.kind = k;
        e.t = t;
        e.val = v;
        sb.push_back(e);
    endtask

    // Given the inputs of cycle t, predict the outputs of cycle t+1
    task automatic model_step(int t, logic [2:0] lvl, bit rst);
        int h;
        bit ls, bs, was_locked, row;
        was_locked = (m_lock == 2);
        if (rst) begin
            m_run = 0;
            m_last_hs = t + 1;
            m_lock = 0;
            m_good = 0;
            m_vert = 0;
            m_armed = 0;
            m_seen = 0;
            m_pend = 0;
            push(K_RS, t + 1, 0);
            if (was_locked) push(K_LK, t + 1, 0);
            return;
        end
        h = t - m_last_hs;
        if (h > 2047) h = 2047;
        ls = (lvl != 0) && (m_run >= 64) && (m_run <= 200);
        bs = (lvl != 0) && (m_run >= 400);
        row = was_locked && (m_vert >= 23) && (m_vert < 310)
              && (h >= 284) && (h < 284 + 1404);
        if (m_pend) begin
            if (m_lock == 0) begin
                m_lock = 1;
                m_good = 0;
            end else if (m_lock == 1) begin
                if (!m_pend_ok) m_good = 0;
                else begin
                    m_good++;
                    if (m_good == 4) m_lock = 2;
                end
            end else if (!m_pend_ok) begin
                m_lock = 0;
            end
        end else if (m_lock == 2 && !ls && h + 1 > 1728 + 16) begin
            m_lock = 0;
        end
        m_pend = ls;
        m_pend_ok = (h >= 1728 - 16) && (h <= 1728 + 16);
        if (ls) begin
            if (m_armed) m_vert = 0;
            else if (m_vert < 511) m_vert++;
            m_armed = 0;
            m_seen = 1;
            m_last_hs = t + 1;
            push(K_HS, t + 1, m_vert);
        end
        if (bs) begin
            if (m_seen) push(K_VS, t + 1, 1);
            m_armed = 1;
            m_seen = 0;
        end
        if ((m_lock == 2) != was_locked) push(K_LK, t + 1, int'(m_lock == 2));
        if (row) push(K_PX, t + 1, int'(lvl));
        if (lvl == 0) m_run = (m_run < 1023) ? m_run + 1 : 1023;
        else m_run = 0;
    endtask

    // ---------------- monitor ----------------
    bit prev_lk = 0;

    task automatic observe(int k, int v);
        exp_t e;
        checks++;
        if (sb.size() > 0 && sb[0].t == cyc && sb[0].kind == k) begin
            e = sb.pop_front();
            if (e.val != v) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%0d required=%0d",
                         kname(k), cyc, v, e.val);
            end
        end else begin
            errors++;
            $display("FAIL unexpected %s cyc=%0d got=%0d required=none",
                     kname(k), cyc, v);
        end
    endtask

    always @(negedge sys_clk) begin
        exp_t e;
        if (cyc >= 1) begin
            while (sb.size() > 0 && sb[0].t < cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missed %s cyc=%0d got=none required=%0d",
                         kname(e.kind), e.t, e.val);
            end
            if (sb.size() > 0 && sb[0].kind == K_RS && sb[0].t == cyc) begin
                e = sb.pop_front();
                checks++;
                if ({row_enable, pixel_level, vert_c, locked,
                     hsync_det, vsync_det} !== {1'b0, 3'b001, 9'd0, 3'b000}) begin
                    errors++;
                    $display("FAIL reset_state cyc=%0d got row=%b pix=%b vert=%0d lk=%b hs=%b vs=%b required 0/001/0/0/0/0",
                             cyc, row_enable, pixel_level, vert_c, locked,
                             hsync_det, vsync_det);
                end
            end
            if (hsync_det === 1'b1) observe(K_HS, int'(vert_c));
            if (vsync_det === 1'b1) observe(K_VS, 1);
            if (locked !== prev_lk) observe(K_LK, int'(locked));
            if (row_enable === 1'b1) begin
                observe(K_PX, int'(pixel_level));
            end else begin
                checks++;
                if (pixel_level !== 3'b001) begin
                    errors++;
                    $display("FAIL idle_level cyc=%0d got=%b required=001",
                             cyc, pixel_level);
                end
            end
            prev_lk = locked;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(logic [2:0] lvl, bit rst);
        @(posedge sys_clk);
        #1;
        level_in = lvl;
        sys_rst = rst;
        model_step(cyc, lvl, rst);
    endtask

    function automatic logic [2:0] rnd_level();
        return 3'($urandom_range(1, 7));
    endfunction

    task automatic line(int slen, int tot, bit pic, int g_at, int g_len);
        logic [2:0] l;
        for (int i = 0; i < tot; i++) begin
            if (i < slen) l = 3'b000;
            else if (g_len > 0 && i >= g_at && i < g_at + g_len) l = 3'b000;
            else l = pic ? rnd_level() : 3'b001;
            drive(l, 1'b0);
        end
    endtask

    task automatic broad();
        for (int i = 0; i < 864; i++) drive((i < 800) ? 3'b000 : 3'b001, 1'b0);
    endtask

    initial begin
        repeat (3) drive(3'b001, 1'b1);
        repeat (20) drive(3'b001, 1'b0);
        // clean lines acquire lock
        repeat (6) line(127, 1728, 1'b0, 0, 0);
        // short glitch and mid-length run inside lines
        line(127, 1728, 1'b1, int'($urandom_range(400, 1200)), 30);
        line(127, 1728, 1'b1, int'($urandom_range(400, 1000)), 300);
        // field start then picture lines with jittered periods
        repeat (5) broad();
        repeat (24) line(127, 1713 + int'($urandom_range(0, 30)), 1'b1, 0, 0);
        // partial picture line, then reset in active picture
        for (int i = 0; i < 827; i++) drive((i < 127) ? 3'b000 : rnd_level(), 1'b0);
        drive(rnd_level(), 1'b1);
        repeat (10) drive(3'b001, 1'b0);
        // relock, short line, relock, then loss of syncs
        repeat (6) line(127, 1728, 1'b0, 0, 0);
        line(127, 1700, 1'b0, 0, 0);
        repeat (6) line(127, 1728, 1'b0, 0, 0);
        repeat (1800) drive(3'b001, 1'b0);
        repeat (3) @(posedge sys_clk);
        #1;
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL leftover %s t=%0d got=none required=%0d",
                     kname(e.kind), e.t, e.val);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
